// File: rtl/lsu_bus.sv
// lsu_bus: single-outstanding load/store unit between a request/response pipe and a memory bus.
// Ports: in_* request side (valid/ready, addr, ren, wen, op, wdata, pass), out_* result side
// (valid/ready, addr, rdata, err, pass), mem_req_* bus request, mem_rsp_* bus response.
// Clock clk, asynchronous active-low reset rst_n.
// Option: LSU_MISALIGN_EXC_EN makes misaligned accesses fault without a bus request;
// when undefined, misaligned offsets are rounded down to the natural size alignment.
module lsu_bus #(
  parameter int XLEN   = 32,
  parameter int PASS_W = 40
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [XLEN-1:0]   in_addr,
  input  logic              in_ren,
  input  logic              in_wen,
  input  logic [2:0]        in_op,
  input  logic [XLEN-1:0]   in_wdata,
  input  logic [PASS_W-1:0] in_pass,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [XLEN-1:0]   out_addr,
  output logic [XLEN-1:0]   out_rdata,
  output logic              out_err,
  output logic [PASS_W-1:0] out_pass,
  output logic              mem_req_valid,
  input  logic              mem_req_ready,
  output logic [XLEN-1:0]   mem_req_addr,
  output logic              mem_req_wen,
  output logic [XLEN-1:0]   mem_req_wdata,
  output logic [XLEN/8-1:0] mem_req_wstrb,
  input  logic              mem_rsp_valid,
  output logic              mem_rsp_ready,
  input  logic [XLEN-1:0]   mem_rsp_rdata,
  input  logic              mem_rsp_err
);
  localparam int NB   = XLEN / 8;
  localparam int OFFW = $clog2(NB);
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] REQ  = 2'd1;
  localparam logic [1:0] RSP  = 2'd2;
  localparam logic [1:0] DONE = 2'd3;
  logic [1:0]        state;
  logic [XLEN-1:0]   addr_q, wdata_q, rdata_q;
  logic [NB-1:0]     wstrb_q;
  logic [PASS_W-1:0] pass_q;
  logic [OFFW-1:0]   off_q;
  logic [1:0]        sz_q;
  logic              sgn_q, wen_q, err_q;
  // Request-side decode: log2 of access bytes, with the "other" codes mapped to full width.
  logic [1:0]      sz;
  logic [OFFW-1:0] amask, off;
  logic [NB-1:0]   strb;
  logic [XLEN-1:0] wsh;
  assign sz    = (in_op[1:0] == 2'b11) ? 2'(OFFW) : in_op[1:0];
  assign amask = OFFW'((1 << sz) - 1);
  assign off   = in_addr[OFFW-1:0] & ~amask;
  assign strb  = NB'((1 << (1 << sz)) - 1) << off;
  assign wsh   = in_wdata << {off, 3'b000};
`ifdef LSU_MISALIGN_EXC_EN
  logic misal;
  assign misal = |(in_addr[OFFW-1:0] & amask);
`endif
  // Response-side extraction: align the selected lanes to bit 0, then extend.
  logic [XLEN-1:0] rsh, keep, ext;
  logic            sbit;
  always_comb begin
    rsh  = mem_rsp_rdata >> {off_q, 3'b000};
    keep = (sz_q == 2'(OFFW)) ? '1 : (XLEN'(1) << (8 << sz_q)) - XLEN'(1);
    sbit = (sz_q == 2'd0) ? rsh[7] : (sz_q == 2'd1) ? rsh[15] : rsh[31];
    ext  = (rsh & keep) | ((sgn_q && sbit) ? ~keep : '0);
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      wstrb_q <= '0;
      pass_q  <= '0;
      off_q   <= '0;
      sz_q    <= '0;
      sgn_q   <= 1'b0;
      wen_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          addr_q  <= in_addr;
          pass_q  <= in_pass;
          off_q   <= off;
          sz_q    <= sz;
          sgn_q   <= ~in_op[2];
          wen_q   <= in_wen;
          wdata_q <= in_wen ? wsh : '0;
          wstrb_q <= in_wen ? strb : '0;
          rdata_q <= '0;
          err_q   <= 1'b0;
          if (!(in_ren || in_wen)) state <= DONE;
`ifdef LSU_MISALIGN_EXC_EN
          else if (misal) begin
            err_q <= 1'b1;
            state <= DONE;
          end
`endif
          else state <= REQ;
        end
        REQ: if (mem_req_ready) state <= RSP;
        RSP: if (mem_rsp_valid) begin
          err_q   <= mem_rsp_err;
          rdata_q <= (mem_rsp_err || wen_q) ? '0 : ext;
          state   <= DONE;
        end
        default: if (out_ready) state <= IDLE;
      endcase
    end
  end
  // in_ready is held low while reset is asserted and rises once released in IDLE.
  assign in_ready      = rst_n && (state == IDLE);
  assign mem_req_valid = (state == REQ);
  assign mem_rsp_ready = (state == RSP);
  assign out_valid     = (state == DONE);
  assign mem_req_addr  = {addr_q[XLEN-1:OFFW], {OFFW{1'b0}}};
  assign mem_req_wen   = wen_q;
  assign mem_req_wdata = wdata_q;
  assign mem_req_wstrb = wstrb_q;
  assign out_addr      = addr_q;
  assign out_rdata     = rdata_q;
  assign out_err       = err_q;
  assign out_pass      = pass_q;
endmodule
